// File: rtl/signal_ctrl_pkg.sv
// signal_ctrl_pkg: opcode, function and condition codes plus last-step decode for the cycle sequencer.
package signal_ctrl_pkg;
  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_LHI   = 5'b00001;
  localparam logic [4:0] OP_LLI   = 5'b00010;
  localparam logic [4:0] OP_LDRRI = 5'b00011;
  localparam logic [4:0] OP_LDRRR = 5'b00100;
  localparam logic [4:0] OP_STRRI = 5'b00101;
  localparam logic [4:0] OP_STRRR = 5'b00110;
  localparam logic [4:0] OP_ADDI  = 5'b00111;
  localparam logic [4:0] OP_SUBI  = 5'b01000;
  localparam logic [4:0] OP_MOV   = 5'b01011;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_JALRL = 5'b10001;
  localparam logic [4:0] OP_JALRR = 5'b10010;
  localparam logic [4:0] OP_JR    = 5'b10011;
  localparam logic [4:0] OP_BCC   = 5'b11000;
  localparam logic [4:0] OP_BAL   = 5'b11001;
  localparam logic [4:0] OP_SYS   = 5'b11100;
  localparam logic [1:0] FN_STR = 2'b00;
  localparam logic [1:0] FN_CMP = 2'b01;
  localparam logic [1:0] FN_OUT = 2'b00;
  localparam logic [1:0] FN_HLT = 2'b01;
  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_CS = 3'b010;
  localparam logic [2:0] CC_CC = 3'b011;
  localparam logic [2:0] L_2 = 3'd2;
  localparam logic [2:0] L_3 = 3'd3;
  localparam logic [2:0] L_4 = 3'd4;
  typedef struct packed {
    logic       valid;
    logic [2:0] l;
  } last_t;
  // HLT is the only class without a final step; everything undecoded behaves as a NOP.
  function automatic last_t last_step(input logic [4:0] m, input logic [1:0] f);
    last_t r;
    r = '{valid: 1'b1, l: L_2};
    case (m)
      OP_ALU, OP_LHI, OP_LLI, OP_ADDI, OP_SUBI, OP_MOV, OP_STRRI,
      OP_BCC, OP_BAL, OP_JALRL, OP_JALRR: r.l = L_3;
      OP_LDRRI, OP_LDRRR:                 r.l = L_4;
      OP_STRRR:                           r.l = (f == FN_STR) ? L_3 : L_2;
      OP_SYS:                             r.valid = (f != FN_HLT);
      default:                            r.l = L_2;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/signal_pcplus1orwb.sv
// signal_pcplus1orwb: selects the write-back bus as PC source on the final step of taken jumps/branches.
module signal_pcplus1orwb
  import signal_ctrl_pkg::*;
(
  input  logic [4:0] InsM,
  input  logic [2:0] InsC,
  input  logic       FlagC,
  input  logic       FlagZ,
  input  logic       Buff_PC,
  output logic       PCplus1orWB
);
  logic cond;
  logic take;
  always_comb begin
    cond = (InsC == CC_NE) ? !FlagZ :
           (InsC == CC_EQ) ?  FlagZ :
           (InsC == CC_CS) ?  FlagC :
           (InsC == CC_CC) ? !FlagC : 1'b0;
    take = (InsM inside {OP_JMP, OP_JR, OP_JALRL, OP_JALRR, OP_BAL}) || (InsM == OP_BCC && cond);
  end
  assign PCplus1orWB = Buff_PC && take;
endmodule

// File: rtl/signal_buff_pc.sv
// signal_buff_pc: per-instruction step counter and final-cycle strobe for the multicycle controller.
// Optional SIGNAL_BUFF_PC_HALTED_EN adds a sticky Halted flag that freezes the counter after HLT.
module signal_buff_pc
  import signal_ctrl_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [4:0]       InsM,
  input  logic [2:0]       InsC,
  input  logic [1:0]       InsL,
  input  logic             FlagC,
  input  logic             FlagZ,
  output logic [CNT_W-1:0] Cnt,
`ifdef SIGNAL_BUFF_PC_HALTED_EN
  output logic             Halted,
`endif
  output logic             Buff_PC,
  output logic             PCplus1orWB
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  last_t ls;
  logic hold;
  assign ls = last_step(InsM, InsL);
  assign Buff_PC = !Rst && ls.valid && cnt_q == CNT_W'(ls.l) && cnt_q >= CNT_W'(2);
`ifdef SIGNAL_BUFF_PC_HALTED_EN
  logic halted_q, halted_d;
  assign hold = halted_q;
  assign halted_d = Rst ? 1'b0 : halted_q || (cnt_q == CNT_W'(2) && InsM == OP_SYS && InsL == FN_HLT);
  assign Halted = halted_q;
  always_ff @(posedge clk) halted_q <= halted_d;
`else
  assign hold = 1'b0;
`endif
  assign cnt_d = (Rst || Buff_PC) ? '0 : (hold || &cnt_q) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign Cnt = cnt_q;
  signal_pcplus1orwb u_pcsel (
    .InsM        (InsM),
    .InsC        (InsC),
    .FlagC       (FlagC),
    .FlagZ       (FlagZ),
    .Buff_PC     (Buff_PC),
    .PCplus1orWB (PCplus1orWB)
  );
endmodule

// File: tb/tb_signal_buff_pc.sv
// tb_signal_buff_pc: directed vectors with hand-computed last steps and PC-select values.
module tb_signal_buff_pc;
  logic       clk = 1'b0;
  logic       Rst;
  logic [4:0] InsM;
  logic [2:0] InsC;
  logic [1:0] InsL;
  logic       FlagC, FlagZ;
  logic [2:0] Cnt;
  logic       Buff_PC, PCplus1orWB;
`ifdef SIGNAL_BUFF_PC_HALTED_EN
  logic       Halted;
`endif
  int n_vec = 0;
  int n_err = 0;

  signal_buff_pc #(.CNT_W(3)) dut (
    .clk         (clk),
    .Rst         (Rst),
    .InsM        (InsM),
    .InsC        (InsC),
    .InsL        (InsL),
    .FlagC       (FlagC),
    .FlagZ       (FlagZ),
    .Cnt         (Cnt),
`ifdef SIGNAL_BUFF_PC_HALTED_EN
    .Halted      (Halted),
`endif
    .Buff_PC     (Buff_PC),
    .PCplus1orWB (PCplus1orWB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [4:0] m, input logic [2:0] c, input logic [1:0] f,
                         input logic z, input logic fc);
    InsM = m; InsC = c; InsL = f; FlagZ = z; FlagC = fc;
    #1;
  endtask

  // Runs one instruction from Cnt=0 and expects the strobe only on step lst.
  task automatic run(input string tag, input logic [4:0] m, input logic [2:0] c, input logic [1:0] f,
                     input logic z, input logic fc, input int lst, input int pc);
    set_ins(m, c, f, z, fc);
    for (int s = 0; s <= lst; s++) begin
      chk({tag, "_cnt"}, Cnt, s);
      chk({tag, "_buff"}, Buff_PC, s == lst);
      chk({tag, "_pc"}, PCplus1orWB, (s == lst) ? pc : 0);
      step();
    end
    chk({tag, "_wrap"}, Cnt, 0);
  endtask

  initial begin
    Rst = 1'b1;
    set_ins(5'b11100, 3'b000, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_cnt", Cnt, 0);
      chk("rst_buff", Buff_PC, 0);
      chk("rst_pc", PCplus1orWB, 0);
    end
    Rst = 1'b0;
    run("outr",  5'b11100, 3'b000, 2'b00, 0, 0, 2, 0);
    run("ldrrr", 5'b00100, 3'b000, 2'b00, 0, 0, 4, 0);
    run("strrr", 5'b00110, 3'b000, 2'b00, 0, 0, 3, 0);
    run("cmp",   5'b00110, 3'b000, 2'b01, 0, 0, 2, 0);
    run("add",   5'b00000, 3'b000, 2'b00, 0, 0, 3, 0);
    run("adc",   5'b00000, 3'b000, 2'b01, 0, 0, 3, 0);
    run("sub",   5'b00000, 3'b000, 2'b10, 0, 0, 3, 0);
    run("sbb",   5'b00000, 3'b000, 2'b11, 0, 0, 3, 0);
    run("lhi",   5'b00001, 3'b000, 2'b00, 0, 0, 3, 0);
    run("mov",   5'b01011, 3'b000, 2'b00, 0, 0, 3, 0);
    run("ldrri", 5'b00011, 3'b000, 2'b00, 0, 0, 4, 0);
    run("beq_t", 5'b11000, 3'b001, 2'b00, 1, 0, 3, 1);
    run("beq_n", 5'b11000, 3'b001, 2'b00, 0, 0, 3, 0);
    run("bne_t", 5'b11000, 3'b000, 2'b00, 0, 1, 3, 1);
    run("bcs_t", 5'b11000, 3'b010, 2'b00, 0, 1, 3, 1);
    run("bcc_n", 5'b11000, 3'b011, 2'b00, 1, 1, 3, 0);
    run("bc4_n", 5'b11000, 3'b100, 2'b00, 1, 1, 3, 0);
    run("bal",   5'b11001, 3'b110, 2'b00, 0, 0, 3, 1);
    run("jmp",   5'b10000, 3'b000, 2'b00, 0, 0, 2, 1);
    run("jr",    5'b10011, 3'b000, 2'b00, 0, 0, 2, 1);
    run("jalrl", 5'b10001, 3'b000, 2'b00, 0, 0, 3, 1);
    run("nop",   5'b11111, 3'b000, 2'b00, 0, 0, 2, 0);
    // Rst on the would-be final step of JMP suppresses both strobes and aborts.
    set_ins(5'b10000, 3'b000, 2'b00, 0, 0);
    step(); step();
    chk("abort_cnt", Cnt, 2);
    Rst = 1'b1;
    #1;
    chk("abort_buff", Buff_PC, 0);
    chk("abort_pc", PCplus1orWB, 0);
    step();
    chk("abort_zero", Cnt, 0);
    Rst = 1'b0;
    #1;
    // Switching to a shorter class after its last step runs the counter to saturation.
    set_ins(5'b00100, 3'b000, 2'b00, 0, 0);
    step(); step(); step();
    set_ins(5'b10000, 3'b000, 2'b00, 0, 0);
    chk("late_buff", Buff_PC, 0);
    for (int i = 0; i < 6; i++) step();
    chk("late_sat", Cnt, 7);
    chk("late_buff2", Buff_PC, 0);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    #1;
    chk("late_rst", Cnt, 0);
    set_ins(5'b11100, 3'b000, 2'b01, 0, 0);
    for (int s = 0; s < 10; s++) begin
`ifdef SIGNAL_BUFF_PC_HALTED_EN
      chk("hlt_cnt", Cnt, (s > 3) ? 3 : s);
      chk("hlt_flag", Halted, s >= 3);
`else
      chk("hlt_cnt", Cnt, (s > 7) ? 7 : s);
`endif
      chk("hlt_buff", Buff_PC, 0);
      chk("hlt_pc", PCplus1orWB, 0);
      step();
    end
    Rst = 1'b1;
    step();
    chk("hlt_rst", Cnt, 0);
`ifdef SIGNAL_BUFF_PC_HALTED_EN
    chk("hlt_rst_flag", Halted, 0);
`endif
    Rst = 1'b0;
    #1;
    run("post",  5'b10001, 3'b000, 2'b00, 0, 0, 3, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
